ddsm_output_stage: RTL
======================

// Module: ddsm_output_stage
// PURPOSE
//  Parametrised output stage of the NC-DDSM: registers the quantiser/network word
//  through a P_DELAY-deep valid-tagged pipeline, then applies a per-sample output
//  mode (pass, offset-binary, clamp, hold) before driving the fractional divider word.
//  Counts clamp events for the monitor. Sits between the noise-coupling network and the divider.
// PARAMETERS
//  P_WIDTH    4   width of i_network / o_frac (two's complement), 2..16
//  P_DELAY    1   pipeline register stages before the mode stage, 1..8
//  P_CLAMP_LO -6  lower clamp bound (signed, must fit P_WIDTH, <= P_CLAMP_HI)
//  P_CLAMP_HI 7   upper clamp bound (signed, must fit P_WIDTH)
//  P_CNT_W    16  width of clamp-event counter
// PORTS
//  i_clk        in   1        system clock
//  i_rst_n      in   1        async active-low reset
//  i_valid      in   1        i_network sample valid (clock-enable of the chain)
//  i_network    in   P_WIDTH  network output word, signed
//  i_mode       in   2        00 pass, 01 offset-binary, 10 clamp, 11 hold
//  i_cnt_clr    in   1        synchronous clear of o_clamp_cnt
//  o_frac       out  P_WIDTH  fractional output word
//  o_valid      out  1        o_frac updated this cycle
//  o_clamp_cnt  out  P_CNT_W  saturating count of clamped samples
//  o_clamp      out  1        current o_frac was clamped
// BEHAVIOUR
//  - One clock, i_clk rising edge; reset asynchronous active-low (i_rst_n). On reset all
//    pipeline data, valid bits, o_frac, o_valid, o_clamp, o_clamp_cnt = 0.
//  - Pipeline: stage k captures {valid,data,mode} from stage k-1 every cycle; stage 0 takes
//    {i_valid,i_network,i_mode}. Data/mode registers load only when incoming valid=1;
//    valid bit always loads. Bubbles propagate as valid=0; no back-pressure.
//  - Mode stage (register P_DELAY+1) acts on the mode captured WITH the sample, so
//    i_mode changes align to data; total latency i_valid -> o_valid = P_DELAY+1 cycles.
//  - For an arriving valid sample d with mode m:
//     00: o_frac<=d; 01: o_frac<=d ^ (1<<(P_WIDTH-1)) (MSB invert);
//     10: o_frac<=max(P_CLAMP_LO,min(P_CLAMP_HI,d)) signed compare; o_clamp<=1 iff changed;
//     11: o_frac holds, o_valid<=0, o_clamp holds.
//    o_valid<=1 for m!=11; o_clamp<=0 in modes 00/01. Invalid arrival: o_frac,o_clamp hold, o_valid<=0.
//  - Counter: +1 when a valid mode-10 sample is clamped; saturates at all-ones (no wrap).
//    i_cnt_clr has priority over increment in the same cycle (result 0).
//  - Reset asserted mid-stream discards in-flight samples; first o_valid after release
//    appears P_DELAY+1 cycles after first i_valid.
// STRUCTURE
//  - ddsm_pkg: mode localparams DDSM_MODE_PASS/OFFS/CLAMP/HOLD, width of mode field.
//  - Sub-module ddsm_pipe_stage (#P_WIDTH): one {valid,data,mode} register with load-on-valid;
//    instantiated P_DELAY times via generate. Mode stage and counter live in top.
//  - Elaboration check: P_CLAMP_LO <= P_CLAMP_HI, both within P_WIDTH signed range.
// TESTING
//  1 Reset: hold i_rst_n=0 with i_valid=1 -> o_frac=0,o_valid=0,o_clamp_cnt=0 throughout.
//  2 Latency: P_DELAY=3, mode 00, i_network=5 one-cycle valid -> o_frac=5,o_valid=1 exactly 4 cycles later, 1-cycle pulse.
//  3 Offset-binary: P_WIDTH=4, mode 01, i_network=-8 -> 0; 7 -> 15 (4'hF).
//  4 Clamp: mode 10, inputs 7,-8,-6,3 -> o_frac 7,-6,-6,3; o_clamp 0,1,0,0; counter=1.
//  5 Hold/mode alignment: switch i_mode 00->11 on sample N -> o_frac frozen at sample N-1, o_valid=0, sample N+1 with mode 00 resumes.
//  6 Counter: P_CNT_W=2, 5 clamped samples -> 3 (saturated); i_cnt_clr with clamp same cycle -> 0.

Source files
------------

// File: rtl/ddsm_pkg.sv
// Shared definitions for the NC-DDSM output stage: output-mode encoding.
package ddsm_pkg;

  localparam int unsigned DDSM_MODE_W = 2;

  typedef logic [DDSM_MODE_W-1:0] ddsm_mode_t;

  localparam ddsm_mode_t DDSM_MODE_PASS  = 2'b00;
  localparam ddsm_mode_t DDSM_MODE_OFFS  = 2'b01;
  localparam ddsm_mode_t DDSM_MODE_CLAMP = 2'b10;
  localparam ddsm_mode_t DDSM_MODE_HOLD  = 2'b11;

endpackage

// File: rtl/ddsm_output_stage_if.sv
// Sample/control bundle between the noise-coupling network and the divider word.
interface ddsm_output_stage_if
  import ddsm_pkg::*;
#(
  parameter int unsigned P_WIDTH = 4,
  parameter int unsigned P_CNT_W = 16
) ();

  logic               i_valid;
  logic [P_WIDTH-1:0] i_network;
  ddsm_mode_t         i_mode;
  logic               i_cnt_clr;
  logic [P_WIDTH-1:0] o_frac;
  logic               o_valid;
  logic [P_CNT_W-1:0] o_clamp_cnt;
  logic               o_clamp;

  // Source side: the network feeding samples and watching the result.
  modport master (
    output i_valid, i_network, i_mode, i_cnt_clr,
    input  o_frac, o_valid, o_clamp_cnt, o_clamp
  );

  // Output stage side.
  modport slave (
    input  i_valid, i_network, i_mode, i_cnt_clr,
    output o_frac, o_valid, o_clamp_cnt, o_clamp
  );

endinterface

// File: rtl/ddsm_pipe_stage.sv
// One valid-tagged pipeline register; payload only loads with a valid sample.
module ddsm_pipe_stage
  import ddsm_pkg::*;
#(
  parameter int unsigned P_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prev_valid,
  input  logic [P_WIDTH-1:0] prev_data,
  input  ddsm_mode_t         prev_mode,
  output logic               valid,
  output logic [P_WIDTH-1:0] data,
  output ddsm_mode_t         mode
);

  // Valid always follows upstream so bubbles propagate; payload freezes on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      mode  <= DDSM_MODE_PASS;
    end else begin
      valid <= prev_valid;
      if (prev_valid) begin
        data <= prev_data;
        mode <= prev_mode;
      end
    end
  end

endmodule

// File: rtl/ddsm_output_stage.sv
// NC-DDSM output stage: delay pipeline, per-sample output mode, clamp-event counter.
module ddsm_output_stage
  import ddsm_pkg::*;
#(
  parameter int unsigned P_WIDTH    = 4,
  parameter int unsigned P_DELAY    = 1,
  parameter int          P_CLAMP_LO = -6,
  parameter int          P_CLAMP_HI = 7,
  parameter int unsigned P_CNT_W    = 16
) (
  input logic                i_clk,
  input logic                i_rst_n,
  ddsm_output_stage_if.slave bus
);

  localparam int SIGNED_MAX = (1 << (P_WIDTH - 1)) - 1;
  localparam int SIGNED_MIN = -SIGNED_MAX - 1;

  localparam logic signed [P_WIDTH-1:0] CLAMP_LO = P_WIDTH'(P_CLAMP_LO);
  localparam logic signed [P_WIDTH-1:0] CLAMP_HI = P_WIDTH'(P_CLAMP_HI);
  localparam logic [P_WIDTH-1:0]        MSB_MASK = {1'b1, {(P_WIDTH - 1){1'b0}}};

  if (P_CLAMP_LO > P_CLAMP_HI || P_CLAMP_LO < SIGNED_MIN || P_CLAMP_HI > SIGNED_MAX)
  begin : gen_bad_clamp
    $error("ddsm_output_stage: clamp bounds invalid for P_WIDTH");
  end

  // Index 0 is the input port, index k+1 is the output of pipeline stage k.
  logic               pipe_valid [P_DELAY+1];
  logic [P_WIDTH-1:0] pipe_data  [P_DELAY+1];
  ddsm_mode_t         pipe_mode  [P_DELAY+1];

  assign pipe_valid[0] = bus.i_valid;
  assign pipe_data[0]  = bus.i_network;
  assign pipe_mode[0]  = bus.i_mode;

  for (genvar k = 0; k < P_DELAY; k++) begin : gen_pipe
    ddsm_pipe_stage #(
      .P_WIDTH (P_WIDTH)
    ) u_stage (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .prev_valid (pipe_valid[k]),
      .prev_data  (pipe_data[k]),
      .prev_mode  (pipe_mode[k]),
      .valid      (pipe_valid[k+1]),
      .data       (pipe_data[k+1]),
      .mode       (pipe_mode[k+1])
    );
  end

  logic                      arr_valid;
  logic [P_WIDTH-1:0]        arr_data;
  ddsm_mode_t                arr_mode;
  logic signed [P_WIDTH-1:0] arr_s;
  logic signed [P_WIDTH-1:0] clamped;
  logic                      clamp_hit;

  assign arr_valid = pipe_valid[P_DELAY];
  assign arr_data  = pipe_data[P_DELAY];
  assign arr_mode  = pipe_mode[P_DELAY];

  // Saturate the arriving sample and flag whether a valid clamp-mode sample was altered.
  always_comb begin
    arr_s   = $signed(arr_data);
    clamped = arr_s;
    if (arr_s > CLAMP_HI) begin
      clamped = CLAMP_HI;
    end else if (arr_s < CLAMP_LO) begin
      clamped = CLAMP_LO;
    end
    clamp_hit = arr_valid && (arr_mode == DDSM_MODE_CLAMP) && (clamped != arr_s);
  end

  logic [P_WIDTH-1:0] frac_q;
  logic               valid_q;
  logic               clamp_q;
  logic [P_CNT_W-1:0] cnt_q;

  // Mode stage: applies the mode that travelled with the sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frac_q  <= '0;
      valid_q <= 1'b0;
      clamp_q <= 1'b0;
    end else if (arr_valid) begin
      unique case (arr_mode)
        DDSM_MODE_PASS: begin
          frac_q  <= arr_data;
          valid_q <= 1'b1;
          clamp_q <= 1'b0;
        end
        DDSM_MODE_OFFS: begin
          frac_q  <= arr_data ^ MSB_MASK;
          valid_q <= 1'b1;
          clamp_q <= 1'b0;
        end
        DDSM_MODE_CLAMP: begin
          frac_q  <= clamped;
          valid_q <= 1'b1;
          clamp_q <= clamp_hit;
        end
        DDSM_MODE_HOLD: begin
          valid_q <= 1'b0;
        end
      endcase
    end else begin
      valid_q <= 1'b0;
    end
  end

  // Saturating clamp-event counter; clear wins over a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (bus.i_cnt_clr) begin
      cnt_q <= '0;
    end else if (clamp_hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.o_frac      = frac_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_clamp     = clamp_q;
  assign bus.o_clamp_cnt = cnt_q;

endmodule
